// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-FF synchronised RX line, start-bit validation and
// 2-of-3 majority sampling around mid-bit, one-cycle data/framing strobes.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       framing_err,
    output logic       busy
);

    // state     | meaning
    // WAIT_IDLE | after reset or a bad stop bit; wait for the line to be high
    // IDLE      | line idle, watching for a falling edge
    // START     | validating the start bit
    // DATA      | receiving 8 data bits, LSB first
    // STOP      | sampling the stop bit
    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    localparam int          H        = CLKS_PER_BIT / 2;
    localparam logic [15:0] C_SAMP0  = 16'(H - 1);
    localparam logic [15:0] C_SAMP1  = 16'(H);
    localparam logic [15:0] C_DECIDE = 16'(H + 1);
    localparam logic [15:0] C_LAST   = 16'(CLKS_PER_BIT - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_rx_meta;
    logic        r_rx_s;
    logic        r_rx_d;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [1:0]  r_samp;
    logic [7:0]  r_shift;
    logic [7:0]  r_data;
    logic        r_data_valid;
    logic        r_framing_err;

    logic        w_busy;
    logic        w_bit_end;
    logic        w_decide;
    logic        w_vote;
    logic        w_load;
    logic        w_ferr;
    logic        w_shift_en;

    assign w_busy    = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);
    assign w_bit_end = (r_cnt == C_LAST);
    assign w_decide  = (r_cnt == C_DECIDE);
    assign w_vote    = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_rx_s) | (r_samp[1] & r_rx_s);

    // First stage is deliberately not reset: it keeps tracking the pin during
    // reset, so a line held low through reset cannot look like an idle-high line.
    always_ff @(posedge clk) begin
        r_rx_meta <= rx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_WAIT_IDLE;
            r_rx_s        <= 1'b1;
            r_rx_d        <= 1'b1;
            r_cnt         <= '0;
            r_bit_idx     <= '0;
            r_samp        <= '0;
            r_shift       <= '0;
            r_data        <= '0;
            r_data_valid  <= 1'b0;
            r_framing_err <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_rx_s        <= r_rx_meta;
            r_rx_d        <= r_rx_s;
            r_data_valid  <= w_load;
            r_framing_err <= w_ferr;

            if (!w_busy || w_bit_end || (w_next != r_state)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end

            if (r_cnt == C_SAMP0) begin
                r_samp[0] <= r_rx_s;
            end
            if (r_cnt == C_SAMP1) begin
                r_samp[1] <= r_rx_s;
            end

            if (r_state != S_DATA) begin
                r_bit_idx <= '0;
            end else if (w_bit_end) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            if (w_shift_en) begin
                r_shift <= {w_vote, r_shift[7:1]};
            end
            if (w_load) begin
                r_data <= r_shift;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_ferr     = 1'b0;
        w_shift_en = 1'b0;
        case (r_state)
            S_WAIT_IDLE: begin
                if (r_rx_s && r_rx_meta) begin
                    w_next = S_IDLE;
                end
            end
            S_IDLE: begin
                if (!r_rx_s && r_rx_d) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                if (w_decide && w_vote) begin
                    w_next = S_IDLE;
                end else if (w_bit_end) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                w_shift_en = w_decide;
                if (w_bit_end && (r_bit_idx == 3'd7)) begin
                    w_next = S_STOP;
                end
            end
            S_STOP: begin
                // Leave at the stop-bit decision so back-to-back frames are caught.
                if (w_decide) begin
                    if (w_vote) begin
                        w_load = 1'b1;
                        w_next = S_IDLE;
                    end else begin
                        w_ferr = 1'b1;
                        w_next = S_WAIT_IDLE;
                    end
                end
            end
            default: begin
                w_next = S_WAIT_IDLE;
            end
        endcase
    end

    assign data        = r_data;
    assign data_valid  = r_data_valid;
    assign framing_err = r_framing_err;
    assign busy        = w_busy;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit; a negedge monitor
// records strobes and busy edges, the main sequence checks them with assertions.
module tb_uart_receiver;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       framing_err;
    logic       busy;

    always #5 clk = ~clk;

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data       (data),
        .data_valid (data_valid),
        .framing_err(framing_err),
        .busy       (busy)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         fall_cyc = 0;
    int         n_valid = 0;
    int         n_ferr = 0;
    int         n_busy_rise = 0;
    int         n_overlap = 0;
    int         n_long = 0;
    int         valid_cyc = 0;
    int         busy_rise_cyc = 0;
    logic [7:0] valid_data = 8'h00;
    logic       prev_dv = 1'b0;
    logic       prev_fe = 1'b0;
    logic       prev_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            n_valid    <= n_valid + 1;
            valid_cyc  <= cyc;
            valid_data <= data;
        end
        if (framing_err === 1'b1) n_ferr <= n_ferr + 1;
        if ((data_valid === 1'b1) && (framing_err === 1'b1)) n_overlap <= n_overlap + 1;
        if (((data_valid === 1'b1) && prev_dv) || ((framing_err === 1'b1) && prev_fe))
            n_long <= n_long + 1;
        if ((busy === 1'b1) && !prev_busy) begin
            n_busy_rise   <= n_busy_rise + 1;
            busy_rise_cyc <= cyc;
        end
        prev_dv   <= (data_valid === 1'b1);
        prev_fe   <= (framing_err === 1'b1);
        prev_busy <= (busy === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bit period; optionally inverts the line for one cycle at offset glitch_at.
    task automatic drive_bit(input logic v, input int glitch_at);
        for (int i = 0; i < CPB; i++) begin
            rx = (i == glitch_at) ? ~v : v;
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int gbit);
        fall_cyc = cyc;
        drive_bit(1'b0, -1);
        for (int k = 0; k < 8; k++) drive_bit(b[k], (k == gbit) ? 9 : -1);
        drive_bit(stop_bit, -1);
    endtask

    initial begin
        rx    = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_data", {24'h0, data}, 32'h00);
        chk("reset_valid", {31'h0, data_valid}, 32'h0);
        chk("reset_ferr", {31'h0, framing_err}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // single frame with latency
        send_frame(8'hA5, 1'b1, -1);
        #1;
        chk("a5_count", n_valid, 1);
        chk("a5_data", {24'h0, valid_data}, 32'hA5);
        chk("a5_held", {24'h0, data}, 32'hA5);
        chk("a5_start_lag", busy_rise_cyc - fall_cyc, 3);
        chk("a5_latency", valid_cyc - busy_rise_cyc, 154);
        chk("a5_busy_after", {31'h0, busy}, 32'h0);
        chk("a5_no_ferr", n_ferr, 0);

        // back-to-back frames
        send_frame(8'h00, 1'b1, -1);
        #1;
        chk("b2b_00_data", {24'h0, valid_data}, 32'h00);
        chk("b2b_00_count", n_valid, 2);
        send_frame(8'hFF, 1'b1, -1);
        #1;
        chk("b2b_ff_data", {24'h0, valid_data}, 32'hFF);
        chk("b2b_ff_count", n_valid, 3);
        chk("b2b_no_ferr", n_ferr, 0);

        // bad stop bit, line stays low afterwards
        send_frame(8'h3C, 1'b0, -1);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        chk("ferr_count", n_ferr, 1);
        chk("ferr_no_valid", n_valid, 3);
        chk("ferr_data_kept", {24'h0, data}, 32'hFF);
        chk("ferr_busy_low", {31'h0, busy}, 32'h0);
        chk("ferr_no_restart", n_busy_rise, 4);
        rx = 1'b1;
        repeat (16) @(negedge clk);
        send_frame(8'h81, 1'b1, -1);
        #1;
        chk("after_ferr_data", {24'h0, data}, 32'h81);
        chk("after_ferr_count", n_valid, 4);

        // 3-cycle glitch on idle line
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        chk("glitch_start_seen", n_busy_rise, 6);
        chk("glitch_no_valid", n_valid, 4);
        chk("glitch_no_ferr", n_ferr, 1);
        chk("glitch_busy_low", {31'h0, busy}, 32'h0);

        // 1-cycle glitch at mid-sample of data bit 0
        send_frame(8'hC3, 1'b1, 0);
        #1;
        chk("vote_data", {24'h0, valid_data}, 32'hC3);
        chk("vote_count", n_valid, 5);

        // reset during data bit 4 of 0x5A
        fall_cyc = cyc;
        drive_bit(1'b0, -1);
        drive_bit(1'b0, -1);
        drive_bit(1'b1, -1);
        drive_bit(1'b0, -1);
        drive_bit(1'b1, -1);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("midreset_busy", {31'h0, busy}, 32'h0);
        chk("midreset_data", {24'h0, data}, 32'h00);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("midreset_no_valid", n_valid, 5);
        chk("midreset_no_ferr", n_ferr, 1);
        send_frame(8'h5A, 1'b1, -1);
        #1;
        chk("midreset_5a_data", {24'h0, data}, 32'h5A);
        chk("midreset_5a_count", n_valid, 6);

        // line held low through reset release
        reset = 1'b1;
        rx    = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        chk("lowrst_no_start", n_busy_rise, 9);
        chk("lowrst_no_valid", n_valid, 6);
        chk("lowrst_no_ferr", n_ferr, 1);
        chk("lowrst_busy", {31'h0, busy}, 32'h0);
        rx = 1'b1;
        repeat (16) @(negedge clk);
        send_frame(8'h12, 1'b1, -1);
        #1;
        chk("lowrst_12_data", {24'h0, data}, 32'h12);
        chk("lowrst_12_count", n_valid, 7);
        chk("lowrst_12_no_ferr", n_ferr, 1);

        chk("strobe_overlap", n_overlap, 0);
        chk("strobe_width", n_long, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
